// File: rtl/seg_pkg.sv
// seg_pkg
// Shared constants for the seven-segment display path.
//   - Glyph constants in active-low form, segment order {g,f,e,d,c,b,a}.
//   - SEG_OFF: all segments dark in active-low form.
//   - IDX_W: width of the digit index. It covers up to 8 digits.
//   - seg_polarity(): converts an active-low glyph to the output polarity.
package seg_pkg;

    localparam int IDX_W = 3;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b0000011;
    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_F = 7'b0001110;

    // Glyphs are stored active-low. Active-high boards need every segment inverted.
    function automatic logic [6:0] seg_polarity(input logic [6:0] glyph_al,
                                                input logic       active_low);
        logic [6:0] res;
        if (active_low) begin
            res = glyph_al;
        end else begin
            res = ~glyph_al;
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_glyph_rom.sv
// seg_glyph_rom
// Combinational decode from a 4-bit code to a 7-segment glyph. The output is
// active-low, with segment order {g,f,e,d,c,b,a}.
// Configuration macro: SEG_HEX_EN
//   - Defined: codes 10..15 show A b C d E F.
//   - Undefined: codes 10..15 show a dark digit.
// Ports:
//   code_i  [3:0]  digit code
//   glyph_o [6:0]  active-low segment pattern
module seg_glyph_rom
    import seg_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] glyph_o
);

    // Glyph lookup. The default arm keeps the output defined for every code.
    always_comb begin
        glyph_o = SEG_OFF;
        case (code_i)
            4'd0:    glyph_o = GLYPH_0;
            4'd1:    glyph_o = GLYPH_1;
            4'd2:    glyph_o = GLYPH_2;
            4'd3:    glyph_o = GLYPH_3;
            4'd4:    glyph_o = GLYPH_4;
            4'd5:    glyph_o = GLYPH_5;
            4'd6:    glyph_o = GLYPH_6;
            4'd7:    glyph_o = GLYPH_7;
            4'd8:    glyph_o = GLYPH_8;
            4'd9:    glyph_o = GLYPH_9;
`ifdef SEG_HEX_EN
            4'd10:   glyph_o = GLYPH_A;
            4'd11:   glyph_o = GLYPH_B;
            4'd12:   glyph_o = GLYPH_C;
            4'd13:   glyph_o = GLYPH_D;
            4'd14:   glyph_o = GLYPH_E;
            4'd15:   glyph_o = GLYPH_F;
`else
            4'd10,
            4'd11,
            4'd12,
            4'd13,
            4'd14,
            4'd15:   glyph_o = SEG_OFF;
`endif
            default: glyph_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_display_mux.sv
// seg_display_mux
// Time-multiplexed driver for a multi-digit seven-segment display.
// A free-running prescaler advances the digit index every REFRESH_DIV cycles.
// The selected digit of the shadow register is decoded and registered onto
// seg_out/an_out, one cycle after the index or the shadow value changes.
// Configuration macro: SEG_HEX_EN (hex glyphs, handled in seg_glyph_rom).
// Parameters: NUM_DIGITS (1..8), REFRESH_DIV (>=2), ACTIVE_LOW (1 = active-low outputs)
// Ports:
//   clk                          rising-edge clock
//   reset                        synchronous active-high reset
//   digits_in [4*NUM_DIGITS-1:0] packed BCD, digit 0 in bits [3:0]
//   load                         capture digits_in into the shadow register
//   enable                       1 = display on, 0 = dark (scan keeps running)
//   blank_lz                     leading-zero blanking enable
//   seg_out   [6:0]              registered segments {g,f,e,d,c,b,a}
//   an_out    [NUM_DIGITS-1:0]   registered digit selects, bit i = digit i
module seg_display_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic                    enable,
    input  logic                    blank_lz,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out
);

    localparam int                    DW           = 4 * NUM_DIGITS;
    localparam int                    PW           = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0]         PRESC_MAX    = PW'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_MAX      = IDX_W'(NUM_DIGITS - 1);
    localparam logic                  AL           = (ACTIVE_LOW != 0);
    localparam logic [6:0]            SEG_INACTIVE = seg_polarity(SEG_OFF, AL);
    localparam logic [NUM_DIGITS-1:0] AN_INACTIVE  = AL ? {NUM_DIGITS{1'b1}}
                                                        : {NUM_DIGITS{1'b0}};

    logic [DW-1:0]         shadow_q, shadow_d;
    logic [PW-1:0]         presc_q,  presc_d;
    logic [IDX_W-1:0]      idx_q,    idx_d;
    logic [6:0]            seg_q,    seg_d;
    logic [NUM_DIGITS-1:0] an_q,     an_d;

    logic                  presc_wrap_s;
    logic [NUM_DIGITS-1:0] an_on_s;
    logic [NUM_DIGITS-1:0] lz_vec_s;
    logic                  lz_run_s;
    logic [3:0]            cur_code_s;
    logic                  cur_lz_s;
    logic                  blank_s;
    logic [6:0]            glyph_s;

    // Shadow register next value: it captures on load and holds otherwise.
    always_comb begin
        shadow_d = shadow_q;
        if (load) begin
            shadow_d = digits_in;
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Prescaler and digit index. The index steps only when the prescaler wraps.
    always_comb begin
        presc_wrap_s = (presc_q == PRESC_MAX);
        presc_d      = presc_q;
        idx_d        = idx_q;
        if (presc_wrap_s) begin
            presc_d = {PW{1'b0}};
            if (idx_q == IDX_MAX) begin
                idx_d = {IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            presc_d = presc_q + PW'(1);
            idx_d   = idx_q;
        end
    end

    // Digit select and leading-zero detection.
    // The loop walks from the most significant digit down. lz_vec_s[i] is set
    // when digit i and every digit above it are zero. The selected code is
    // picked with a one-hot AND-OR, so an index outside the digit range gives 0.
    always_comb begin
        an_on_s    = {NUM_DIGITS{1'b0}};
        lz_vec_s   = {NUM_DIGITS{1'b0}};
        lz_run_s   = 1'b1;
        cur_code_s = 4'h0;
        cur_lz_s   = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            an_on_s[i]  = (idx_q == IDX_W'(i));
            lz_run_s    = lz_run_s & (shadow_q[4*i +: 4] == 4'h0);
            lz_vec_s[i] = lz_run_s;
            cur_code_s  = cur_code_s | (shadow_q[4*i +: 4] & {4{an_on_s[i]}});
            cur_lz_s    = cur_lz_s | (lz_vec_s[i] & an_on_s[i]);
        end
        // Digit 0 is never blanked, so a value of zero still shows "0".
        blank_s = blank_lz & cur_lz_s & (idx_q != {IDX_W{1'b0}});
    end

    seg_glyph_rom u_glyph_rom (
        .code_i  (cur_code_s),
        .glyph_o (glyph_s)
    );

    // Output next values. When disabled, everything is dark but the scan keeps running.
    always_comb begin
        seg_d = SEG_INACTIVE;
        an_d  = AN_INACTIVE;
        if (enable) begin
            if (blank_s) begin
                seg_d = seg_polarity(SEG_OFF, AL);
            end else begin
                seg_d = seg_polarity(glyph_s, AL);
            end
            if (AL) begin
                an_d = ~an_on_s;
            end else begin
                an_d = an_on_s;
            end
        end else begin
            seg_d = SEG_INACTIVE;
            an_d  = AN_INACTIVE;
        end
    end

    // State and output registers. Reset takes priority over load and restarts
    // the scan at digit 0 with a full prescaler period.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= {DW{1'b0}};
            presc_q  <= {PW{1'b0}};
            idx_q    <= {IDX_W{1'b0}};
            seg_q    <= SEG_INACTIVE;
            an_q     <= AN_INACTIVE;
        end else begin
            shadow_q <= shadow_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign seg_out = seg_q;
    assign an_out  = an_q;

endmodule

// File: doc/seg_display_mux.md
SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, range 1..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 50000: clock cycles each digit is shown, minimum 2.
REQ-003 SHALL have parameter ACTIVE_LOW, default 1: when 1, segment and anode outputs are active-low.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port digits_in, input, 4*NUM_DIGITS bits: packed BCD digits, digit 0 in bits [3:0] (least significant).
REQ-007 SHALL have port load, input, 1 bit: capture digits_in into the shadow register on this edge.
REQ-008 SHALL have port enable, input, 1 bit: display on when high, dark when low.
REQ-009 SHALL have port blank_lz, input, 1 bit: enable leading-zero blanking.
REQ-010 SHALL have port seg_out, output, 7 bits: segments ordered {g,f,e,d,c,b,a}, registered.
REQ-011 SHALL have port an_out, output, NUM_DIGITS bits: one digit-select per digit, bit i selects digit i, registered.

Function
REQ-012 SHALL hold a shadow register of 4*NUM_DIGITS bits, loaded from digits_in when load=1; otherwise it holds its value.
REQ-013 SHALL run a prescaler that counts 0..REFRESH_DIV-1 and wraps; at terminal count, the digit index advances by one, wrapping NUM_DIGITS-1 to 0.
REQ-014 SHALL register seg_out/an_out every cycle from the current index and shadow value, giving 1 cycle of latency from an index change or load to the output.
REQ-015 SHALL, with enable=1, drive exactly one an_out bit active (the bit at the index) and drive seg_out with that digit's glyph.
REQ-016 SHALL, with enable=0, drive all an_out and seg_out bits inactive from the next edge; the prescaler and index keep running.
REQ-017 SHALL use these glyphs, shown active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-018 SHALL, when blank_lz=1, blank digit i (all segments off, anode still active) if digit i and every more significant digit are zero; digit 0 is never blanked.
REQ-019 SHALL, when load and a prescaler wrap occur in the same cycle, display the new shadow value at the new index on the next edge.
REQ-020 SHALL, when ACTIVE_LOW=0, invert both seg_out and an_out relative to REQ-017.

Reset
REQ-021 SHALL, when reset=1 at an edge, clear the shadow register, prescaler and index to 0, and drive seg_out and an_out all-inactive; reset has priority over load.
REQ-022 SHALL give reset asserted mid-scan the same result as REQ-021; scanning restarts at digit 0 with a full REFRESH_DIV period.

Configuration
REQ-023 SHALL, when SEG_HEX_EN is defined, display codes 10..15 as A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 (active-low form).
REQ-024 SHALL, when SEG_HEX_EN is undefined, display codes 10..15 as blank (all segments off); outputs are never X.

Structure
REQ-025 SHALL take the glyph constants and the segment-off constant from a shared package, seg_pkg.
REQ-026 SHALL place the combinational 4-bit to 7-segment decode in the sub-module seg_glyph_rom, which contains the SEG_HEX_EN switch; seg_display_mux instantiates it once.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1)
REQ-027 SHALL check reset: hold reset for 2 cycles -> seg_out=1111111, an_out=1111.
REQ-028 SHALL check scanning: load 16'h1234 with enable=1 -> an_out=1110 with seg 0011001 ("4"); 4 cycles later an_out=1101 with seg 0110000 ("3"); sequence wraps after 16 cycles.
REQ-029 SHALL check blanking: load 16'h0070 with blank_lz=1 -> digits 3 and 2 show 1111111, digit 1 shows 1111000, digit 0 shows 1000000; with blank_lz=0, digit 3 shows 1000000.
REQ-030 SHALL check hex mode: load 16'h00A0 -> digit 1 shows 0001000 with SEG_HEX_EN defined, 1111111 without it.
REQ-031 SHALL check enable: drop enable while digit 2 is active -> all outputs 1 on the next edge; re-raise enable 3 cycles later -> the display resumes at the index the free-running counter has reached.
REQ-032 SHALL check reset mid-scan: assert reset while digit 3 is active -> outputs all 1 on the next edge; after release, digit 0 is active on the first cycle and digits_in must be reloaded to show data.
